// File: rtl/mem_system.sv
// mem_system: direct-mapped, write-back, write-allocate cache (256 lines x 4 words x 16b)
// in front of a four-bank word memory with a pipelined two-cycle read latency.
module mem_system (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] Addr,
   input  logic [15:0] DataIn,
   input  logic        Rd,
   input  logic        Wr,
   input  logic        createdump,
   output logic [15:0] DataOut,
   output logic        Done,
   output logic        Stall,
   output logic        CacheHit
);
   localparam int unsigned LINES      = 256;
   localparam int unsigned BANK_WORDS = 8192;
   localparam int unsigned TAG_W      = 5;
   localparam int unsigned IDX_W      = 8;
   localparam int unsigned BADDR_W    = TAG_W + IDX_W;

   typedef enum logic [3:0] {
      IDLE, WB0, WB1, WB2, WB3, RD0, RD1, RD2, RD3, FILL0, FILL1, DONE
   } state_t;

   state_t state, state_nxt;

   // cache storage
   logic [15:0]       cdata [LINES][4];
   logic [TAG_W-1:0]  ctag  [LINES];
   logic [LINES-1:0]  cvalid;
   logic [LINES-1:0]  cdirty;

   // main memory: bank = word offset, so a line's four words hit four different banks
   // and the round-robin access pattern never produces a bank conflict
   logic [15:0]                     bank [4][BANK_WORDS];
   logic [3:0][BANK_WORDS-1:0]      bank_init;

   // latched request for the duration of a miss
   logic [15:0] req_addr, req_data;
   logic        req_wr;

   logic [15:0]        cur_addr, cur_data;
   logic               cur_wr, req_c, hit_c;
   logic [IDX_W-1:0]   idx;
   logic [TAG_W-1:0]   tg;
   logic [1:0]         off;
   logic [BADDR_W-1:0] vic_addr, rd_addr;

   logic       acc_wr_c, mem_we_c, mem_re_c, fill_set_c;
   logic [1:0] seq_off;

   // read pipeline (two stages = memory latency)
   logic        rd_v1, rd_v2;
   logic [1:0]  rd_off1, rd_off2;
   logic [15:0] rd_d1, rd_d2;

   logic unused_c;
   assign unused_c = ^{createdump, Addr[0]};

   assign cur_addr = (state == IDLE) ? Addr   : req_addr;
   assign cur_data = (state == IDLE) ? DataIn : req_data;
   assign cur_wr   = (state == IDLE) ? Wr     : req_wr;
   assign idx      = cur_addr[10:3];
   assign tg       = cur_addr[15:11];
   assign off      = cur_addr[2:1];
   assign vic_addr = {ctag[idx], idx};
   assign rd_addr  = {tg, idx};
   assign req_c    = Rd | Wr;
   assign hit_c    = (state == IDLE) && req_c && cvalid[idx] && (ctag[idx] == tg);
   assign Stall    = (state != IDLE) && (state != DONE);

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // capture the request when it is accepted in IDLE
   always_ff @(posedge clk) begin
      if (rst) begin
         req_addr <= '0;
         req_data <= '0;
         req_wr   <= 1'b0;
      end else if (state == IDLE && req_c) begin
         req_addr <= Addr;
         req_data <= DataIn;
         req_wr   <= Wr;
      end
   end

   // next-state and control decode
   always_comb begin
      state_nxt  = state;
      Done       = 1'b0;
      CacheHit   = 1'b0;
      DataOut    = '0;
      acc_wr_c   = 1'b0;
      mem_we_c   = 1'b0;
      mem_re_c   = 1'b0;
      fill_set_c = 1'b0;
      seq_off    = 2'd0;
      unique case (state)
         IDLE: begin
            if (req_c) begin
               if (hit_c) begin
                  Done     = 1'b1;
                  CacheHit = 1'b1;
                  if (Wr) acc_wr_c = 1'b1;
                  else    DataOut  = cdata[idx][off];
               end else if (cvalid[idx] && cdirty[idx]) begin
                  state_nxt = WB0;
               end else begin
                  state_nxt = RD0;
               end
            end
         end
         WB0:   begin mem_we_c = 1'b1; seq_off = 2'd0; state_nxt = WB1; end
         WB1:   begin mem_we_c = 1'b1; seq_off = 2'd1; state_nxt = WB2; end
         WB2:   begin mem_we_c = 1'b1; seq_off = 2'd2; state_nxt = WB3; end
         WB3:   begin mem_we_c = 1'b1; seq_off = 2'd3; state_nxt = RD0; end
         RD0:   begin mem_re_c = 1'b1; seq_off = 2'd0; state_nxt = RD1; end
         RD1:   begin mem_re_c = 1'b1; seq_off = 2'd1; state_nxt = RD2; end
         RD2:   begin mem_re_c = 1'b1; seq_off = 2'd2; state_nxt = RD3; end
         RD3:   begin mem_re_c = 1'b1; seq_off = 2'd3; state_nxt = FILL0; end
         FILL0: state_nxt = FILL1;
         FILL1: begin fill_set_c = 1'b1; state_nxt = DONE; end
         DONE: begin
            Done = 1'b1;
            if (cur_wr) acc_wr_c = 1'b1;
            else        DataOut  = cdata[idx][off];
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // memory writes (writeback); unwritten words read as zero after reset
   always_ff @(posedge clk) begin
      if (rst) begin
         bank_init <= '0;
      end else if (mem_we_c) begin
         bank[seq_off][vic_addr]      <= cdata[idx][seq_off];
         bank_init[seq_off][vic_addr] <= 1'b1;
      end
   end

   // memory read pipeline
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_v1   <= 1'b0;
         rd_v2   <= 1'b0;
         rd_off1 <= 2'd0;
         rd_off2 <= 2'd0;
         rd_d1   <= '0;
         rd_d2   <= '0;
      end else begin
         rd_v1   <= mem_re_c;
         rd_off1 <= seq_off;
         rd_d1   <= bank_init[seq_off][rd_addr] ? bank[seq_off][rd_addr] : 16'h0000;
         rd_v2   <= rd_v1;
         rd_off2 <= rd_off1;
         rd_d2   <= rd_d1;
      end
   end

   // cache data and tag updates (fill and access writes never overlap in time)
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (rd_v2)      cdata[idx][rd_off2] <= rd_d2;
         if (acc_wr_c)   cdata[idx][off]     <= cur_data;
         if (fill_set_c) ctag[idx]           <= tg;
      end
   end

   // valid/dirty bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         cvalid <= '0;
         cdirty <= '0;
      end else begin
         if (fill_set_c) begin
            cvalid[idx] <= 1'b1;
            cdirty[idx] <= 1'b0;
         end
         if (acc_wr_c) cdirty[idx] <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_system.sv
// tb_mem_system: directed and random requests against mem_system, checked through a
// scoreboard queue against a flat word memory.
module tb_mem_system;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] Addr = '0;
   logic [15:0] DataIn = '0;
   logic        Rd = 1'b0;
   logic        Wr = 1'b0;
   logic        createdump = 1'b0;
   logic [15:0] DataOut;
   logic        Done, Stall, CacheHit;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic        rd;
      logic [15:0] addr;
      logic [15:0] data;
      logic        chk_hit;
      logic        hit;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [15:0] model [32768];

   mem_system dut (
      .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
      .createdump(createdump), .DataOut(DataOut), .Done(Done), .Stall(Stall),
      .CacheHit(CacheHit)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32768; i++) model[i] = 16'h0000;
   endtask

   // issue one request, wait for Done within a bound, check latency and Stall
   task automatic do_req(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [15:0] d, input logic chk_hit, input logic hit,
                         input int lo, input int hi);
      exp_t e;
      int   lat;
      logic stall_bad;
      if (wr) model[a[15:1]] = d;
      e.rd      = rd & ~wr;
      e.addr    = a;
      e.data    = model[a[15:1]];
      e.chk_hit = chk_hit;
      e.hit     = hit;
      sb.push_back(e);
      Rd = rd; Wr = wr; Addr = a; DataIn = d;
      lat = 0;
      stall_bad = 1'b0;
      @(negedge clk);
      while (!Done && lat < 30) begin
         @(negedge clk);
         lat++;
         if (!Done && !Stall) stall_bad = 1'b1;
      end
      if (!Done) begin
         fails++;
         $display("FAIL timeout: no Done for addr %h after %0d cycles", a, lat);
         $display("[TB] %0d tests run, %0d failed", tests, fails);
         $fatal(1, "request timeout");
      end
      tests++;
      if (lat < lo || lat > hi) begin
         fails++;
         $display("FAIL latency addr %h: got %0d required %0d..%0d", a, lat, lo, hi);
      end
      check("stall_during_miss", 16'(stall_bad), 16'h0000);
      check("stall_at_done", 16'(Stall), 16'h0000);
      @(posedge clk);
      #1;
      Rd = 1'b0; Wr = 1'b0;
   endtask

   // monitor: every Done must match the oldest outstanding request
   always @(negedge clk) begin
      if (!rst && Done) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL spurious_done: Done with no outstanding request (t=%0t)", $time);
         end else begin
            mon_e = sb.pop_front();
            if (mon_e.rd)      check("rd_data", DataOut, mon_e.data);
            if (mon_e.chk_hit) check("cache_hit", 16'(CacheHit), 16'(mon_e.hit));
         end
      end
   end

   initial begin
      logic [15:0] a, d;
      logic        w;
      model_clear();
      rst = 1'b1;
      @(negedge clk);
      check("rst_done", 16'(Done), 16'h0000);
      check("rst_stall", 16'(Stall), 16'h0000);
      check("rst_hit", 16'(CacheHit), 16'h0000);
      check("rst_dataout", DataOut, 16'h0000);
      @(posedge clk);
      #1 rst = 1'b0;

      // directed sequence: rd, wr, rd, wr/rd, hit, miss, min, max
      do_req(1, 0, 16'h0010, 16'h0000, 1, 0, 3, 20);  // cold miss
      do_req(0, 1, 16'h0010, 16'h1234, 1, 1, 0, 0);   // write hit, same-cycle Done
      do_req(1, 0, 16'h0010, 16'h0000, 1, 1, 0, 2);   // read hit
      do_req(1, 0, 16'h0810, 16'h0000, 1, 0, 3, 20);  // dirty eviction
      do_req(1, 0, 16'h0010, 16'h0000, 1, 0, 3, 20);  // writeback visible
      do_req(1, 1, 16'h0012, 16'hBEEF, 1, 1, 0, 2);   // Rd&Wr treated as write
      do_req(1, 0, 16'h0012, 16'h0000, 1, 1, 0, 2);
      do_req(0, 1, 16'h0816, 16'h5A5A, 1, 0, 3, 20);  // write-allocate miss
      do_req(1, 0, 16'h0012, 16'h0000, 1, 0, 3, 20);
      do_req(1, 0, 16'h0816, 16'h0000, 1, 0, 3, 20);
      do_req(1, 0, 16'hFFFE, 16'h0000, 1, 0, 3, 20);  // top tag/index/offset
      do_req(0, 1, 16'hFFFE, 16'hCAFE, 1, 1, 0, 0);
      do_req(1, 0, 16'hFFFE, 16'h0000, 1, 1, 0, 2);

      // reset in the middle of a miss aborts it and clears cache and memory
      Rd = 1'b1; Addr = 16'h0020;
      @(negedge clk);
      repeat (3) @(negedge clk);
      check("stall_mid_miss", 16'(Stall), 16'h0001);
      @(posedge clk);
      #1 rst = 1'b1; Rd = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      model_clear();
      do_req(1, 0, 16'h0010, 16'h0000, 1, 0, 3, 20);

      // random trace over a small footprint to force hits and evictions
      for (int n = 0; n < 1000; n++) begin
         a = {3'b000, 2'($urandom_range(0, 3)), 6'b000000, 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1))};
         d = 16'($urandom);
         w = ($urandom_range(0, 9) < 4);
         do_req(~w, w, a, d, 0, 0, 0, 20);
      end

      repeat (3) @(negedge clk);
      check("sb_empty", 16'(sb.size()), 16'h0000);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
